// File: rtl/motor_pkg.sv
// Shared types, default timing constants and decode helpers for the motor H-bridge driver.
// Pure declarations: no latency, no flow control.
package motor_pkg;

  typedef enum logic [1:0] {IDLE, RUN_FWD, RUN_REV, DEAD} chanState_t;
  typedef enum logic [1:0] {STOP, FWD, REV} cmd_t;

  localparam int DEF_PERIOD      = 5000;
  localparam int DEF_DUTY_1      = 2500;
  localparam int DEF_DUTY_2      = 3750;
  localparam int DEF_DUTY_3      = 5000;
  localparam int DEF_DEAD_CYCLES = 10000;

  // Both requests high is treated as STOP so the bridge is never energised.
  function automatic cmd_t decodeCmd(input logic fwd, input logic bwd);
    if (fwd && !bwd) return FWD;
    if (bwd && !fwd) return REV;
    return STOP;
  endfunction

  function automatic int dutyMap(input logic [1:0] code, input int d1, input int d2, input int d3);
    case (code)
      2'd1:    return d1;
      2'd2:    return d2;
      2'd3:    return d3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One wheel: direction FSM with reversal dead time, period-aligned duty latch, registered pin drive.
// Outputs change one cycle after inputs; no backpressure, commands are level-sampled every cycle.
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_1      = DEF_DUTY_1,
  parameter int DUTY_2      = DEF_DUTY_2,
  parameter int DUTY_3      = DEF_DUTY_3,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fwd,
  input  logic          bwd,
  input  logic [1:0]    speed,
  input  logic [CW-1:0] cntNext,
  input  logic          wrap,
  output logic          en,
  input  logic          dummyUnused,
  output logic          inA,
  output logic          inB,
  output logic          dead
);

  localparam int DW = $clog2(PERIOD + 1);
  localparam int KW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  cmd_t         cmd;
  chanState_t   state;
  int           dutyRaw;
  logic [DW-1:0] dutyMapped;
  logic [DW-1:0] dutyLatched;
  logic [DW-1:0] dutyNext;
  logic [KW-1:0] deadCnt;
  logic          pwmOn;

  assign cmd        = decodeCmd(fwd, bwd);
  assign dutyRaw    = dutyMap(speed, DUTY_1, DUTY_2, DUTY_3);
  assign dutyMapped = (dutyRaw >= PERIOD) ? DW'(PERIOD) : DW'(dutyRaw);

  // EN is registered against the count of the coming cycle, so a freshly
  // latched duty is already in effect when the counter shows 0.
  assign dutyNext = wrap ? dutyMapped : dutyLatched;
  assign pwmOn    = DW'(cntNext) < dutyNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dutyLatched <= '0;
      deadCnt     <= '0;
      en          <= 1'b0;
      inA         <= 1'b0;
      inB         <= 1'b0;
      dead        <= 1'b0;
    end else begin
      if (wrap) dutyLatched <= dutyMapped;
      en   <= 1'b0;
      inA  <= 1'b0;
      inB  <= 1'b0;
      dead <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd == FWD) begin
            state <= RUN_FWD;
            inA   <= 1'b1;
            en    <= pwmOn;
          end else if (cmd == REV) begin
            state <= RUN_REV;
            inB   <= 1'b1;
            en    <= pwmOn;
          end
        end
        RUN_FWD: begin
          if (cmd == FWD) begin
            inA <= 1'b1;
            en  <= pwmOn;
          end else if (cmd == REV) begin
            state   <= DEAD;
            deadCnt <= KW'(DEAD_CYCLES - 1);
            dead    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN_REV: begin
          if (cmd == REV) begin
            inB <= 1'b1;
            en  <= pwmOn;
          end else if (cmd == FWD) begin
            state   <= DEAD;
            deadCnt <= KW'(DEAD_CYCLES - 1);
            dead    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DEAD: begin
          // The interval is fixed once entered; only the command present at expiry matters.
          if (deadCnt == '0) begin
            if (cmd == FWD) begin
              state <= RUN_FWD;
              inA   <= 1'b1;
              en    <= pwmOn;
            end else if (cmd == REV) begin
              state <= RUN_REV;
              inB   <= 1'b1;
              en    <= pwmOn;
            end else begin
              state <= IDLE;
            end
          end else begin
            deadCnt <= deadCnt - 1'b1;
            dead    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motor_pwm_bridge.sv
// Two-wheel L298N-style bridge driver sharing one PWM period counter across both channels.
// All pins registered, one cycle after the command; duty changes take effect at the next period start.
module motor_pwm_bridge
  import motor_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_1      = DEF_DUTY_1,
  parameter int DUTY_2      = DEF_DUTY_2,
  parameter int DUTY_3      = DEF_DUTY_3,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Forward1,
  input  logic       Backwards1,
  input  logic       Forward2,
  input  logic       Backwards2,
  input  logic [1:0] speedL,
  input  logic [1:0] speedR,
  output logic       ENA,
  output logic       IN1,
  output logic       IN2,
  output logic       ENB,
  output logic       IN3,
  output logic       IN4,
  output logic       deadL,
  output logic       deadR
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic          wrap;

  assign wrap    = (cnt == CW'(PERIOD - 1));
  assign cntNext = wrap ? '0 : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cntNext;
  end

  motor_pwm_channel #(
    .PERIOD(PERIOD), .DUTY_1(DUTY_1), .DUTY_2(DUTY_2), .DUTY_3(DUTY_3), .DEAD_CYCLES(DEAD_CYCLES)
  ) chanL (
    .clk(clk), .reset(reset), .fwd(Forward1), .bwd(Backwards1), .speed(speedL),
    .cntNext(cntNext), .wrap(wrap), .dummyUnused(1'b0),
    .en(ENA), .inA(IN1), .inB(IN2), .dead(deadL)
  );

  motor_pwm_channel #(
    .PERIOD(PERIOD), .DUTY_1(DUTY_1), .DUTY_2(DUTY_2), .DUTY_3(DUTY_3), .DEAD_CYCLES(DEAD_CYCLES)
  ) chanR (
    .clk(clk), .reset(reset), .fwd(Forward2), .bwd(Backwards2), .speed(speedR),
    .cntNext(cntNext), .wrap(wrap), .dummyUnused(1'b0),
    .en(ENB), .inA(IN3), .inB(IN4), .dead(deadR)
  );

  // Shoot-through on either bridge would short the supply.
  noShootL: assert property (@(posedge clk) !(IN1 && IN2));
  noShootR: assert property (@(posedge clk) !(IN3 && IN4));
  noEnInDeadL: assert property (@(posedge clk) !(deadL && ENA));
  noEnInDeadR: assert property (@(posedge clk) !(deadR && ENB));

endmodule

// File: tb/tb_motor_pwm_bridge.sv
// Randomised and directed bench for motor_pwm_bridge against a signed-direction reference model.
module tb_motor_pwm_bridge;

  localparam int P  = 100;
  localparam int D1 = 40;
  localparam int D2 = 70;
  localparam int D3 = 100;
  localparam int DC = 20;

  logic clk = 1'b0;
  logic reset;
  logic Forward1, Backwards1, Forward2, Backwards2;
  logic [1:0] speedL, speedR;
  logic ENA, IN1, IN2, ENB, IN3, IN4, deadL, deadR;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  motor_pwm_bridge #(
    .PERIOD(P), .DUTY_1(D1), .DUTY_2(D2), .DUTY_3(D3), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .Forward1(Forward1), .Backwards1(Backwards1), .Forward2(Forward2), .Backwards2(Backwards2),
    .speedL(speedL), .speedR(speedR),
    .ENA(ENA), .IN1(IN1), .IN2(IN2), .ENB(ENB), .IN3(IN3), .IN4(IN4),
    .deadL(deadL), .deadR(deadR)
  );

  // Reference model: direction as +1/0/-1, dead time as a remaining-cycle count.
  typedef struct {
    int dir;
    int deadLeft;
    bit inDead;
    int duty;
  } chan_t;

  chan_t mL, mR;
  int    pcnt;

  function automatic int refDuty(input logic [1:0] code);
    int d;
    d = (code == 2'd1) ? D1 : (code == 2'd2) ? D2 : (code == 2'd3) ? D3 : 0;
    return (d > P) ? P : d;
  endfunction

  function automatic chan_t chanStep(input chan_t c, input bit f, input bit b,
                                     input logic [1:0] spd, input bit wrapNow);
    chan_t n;
    int cmd;
    n   = c;
    cmd = (f && !b) ? 1 : (b && !f) ? -1 : 0;
    if (wrapNow) n.duty = refDuty(spd);
    if (c.inDead) begin
      if (c.deadLeft == 0) begin
        n.inDead = 1'b0;
        n.dir    = cmd;
      end else begin
        n.deadLeft = c.deadLeft - 1;
      end
    end else if (c.dir == 0) begin
      n.dir = cmd;
    end else if (cmd == 0) begin
      n.dir = 0;
    end else if (cmd == -c.dir) begin
      n.dir      = 0;
      n.inDead   = 1'b1;
      n.deadLeft = DC - 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] expOf(input chan_t c, input int pc);
    return {(c.dir != 0) && (pc < c.duty), c.dir == 1, c.dir == -1, c.inDead};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mL   <= '{0, 0, 1'b0, 0};
      mR   <= '{0, 0, 1'b0, 0};
      pcnt <= 0;
    end else begin
      mL   <= chanStep(mL, Forward1, Backwards1, speedL, pcnt == P - 1);
      mR   <= chanStep(mR, Forward2, Backwards2, speedR, pcnt == P - 1);
      pcnt <= (pcnt == P - 1) ? 0 : pcnt + 1;
    end
  end

  logic [7:0] dutOuts, expOuts;
  assign dutOuts = {ENA, IN1, IN2, deadL, ENB, IN3, IN4, deadR};
  assign expOuts = {expOf(mL, pcnt), expOf(mR, pcnt)};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int highs;
    reset = 1'b1; Forward1 = 1'b1; Backwards1 = 1'b0; Forward2 = 1'b0; Backwards2 = 1'b0;
    speedL = 2'd2; speedR = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dutOuts !== 8'h00) begin
        fails++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=00000000", i, dutOuts);
      end
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({IN1, IN2} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release_dir got IN1IN2=%b want=10", {IN1, IN2});
    end
    for (int g = 0; g < 2 * P && pcnt != 0; g++) tick();
    for (int per = 0; per < 2; per++) begin
      highs = 0;
      for (int i = 0; i < P; i++) begin
        tests++;
        if (dutOuts !== expOuts) begin
          fails++;
          $display("FAIL reset_model t=%0t got=%b want=%b", $time, dutOuts, expOuts);
        end
        highs += int'(ENA);
        tick();
      end
      tests++;
      if (highs != 70) begin
        fails++;
        $display("FAIL reset_duty70 period=%0d got=%0d want=70", per, highs);
      end
    end
  endtask

  task automatic test_speed_change();
    int highs;
    int want[2] = '{70, 40};
    for (int g = 0; g < 2 * P && pcnt != 0; g++) tick();
    for (int per = 0; per < 2; per++) begin
      highs = 0;
      for (int i = 0; i < P; i++) begin
        tests++;
        if (dutOuts !== expOuts) begin
          fails++;
          $display("FAIL speed_model t=%0t got=%b want=%b", $time, dutOuts, expOuts);
        end
        highs += int'(ENA);
        if (per == 0 && i == 30) speedL = 2'd1;
        tick();
      end
      tests++;
      if (highs != want[per]) begin
        fails++;
        $display("FAIL speed_change period=%0d got=%0d want=%0d", per, highs, want[per]);
      end
    end
  endtask

  task automatic test_reversal();
    int deadCycles = 0;
    int enDuringDead = 0;
    speedL = 2'd3;
    Forward1 = 1'b0; Backwards1 = 1'b1;
    tick();
    tests++;
    if ({IN1, IN2, deadL} !== 3'b001) begin
      fails++;
      $display("FAIL reversal_enter got IN1IN2dead=%b want=001", {IN1, IN2, deadL});
    end
    for (int g = 0; g < 100 && deadL === 1'b1; g++) begin
      deadCycles++;
      if (ENA !== 1'b0 || (IN1 && IN2)) enDuringDead++;
      tests++;
      if (dutOuts !== expOuts) begin
        fails++;
        $display("FAIL reversal_model t=%0t got=%b want=%b", $time, dutOuts, expOuts);
      end
      tick();
    end
    tests++;
    if (deadCycles != DC) begin
      fails++;
      $display("FAIL reversal_dead_len got=%0d want=%0d", deadCycles, DC);
    end
    tests++;
    if (enDuringDead != 0) begin
      fails++;
      $display("FAIL reversal_en_in_dead got=%0d cycles want=0", enDuringDead);
    end
    tests++;
    if ({IN1, IN2, ENA} !== 3'b011) begin
      fails++;
      $display("FAIL reversal_exit got IN1IN2ENA=%b want=011", {IN1, IN2, ENA});
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    int lowEn = 0;
    Forward2 = 1'b1; Backwards2 = 1'b1; speedR = 2'd3;
    for (int i = 0; i < 250; i++) begin
      tick();
      if ({IN3, IN4, ENB} !== 3'b000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL illegal_both got=%0d energised cycles want=0", bad);
    end
    Backwards2 = 1'b0;
    tick();
    tests++;
    if ({IN3, IN4} !== 2'b10) begin
      fails++;
      $display("FAIL illegal_release got IN3IN4=%b want=10", {IN3, IN4});
    end
    for (int g = 0; g < 2 * P && pcnt != 0; g++) tick();
    for (int i = 0; i < P; i++) begin
      if (ENB !== 1'b1) lowEn++;
      tick();
    end
    tests++;
    if (lowEn != 0) begin
      fails++;
      $display("FAIL illegal_full_duty got=%0d low cycles want=0", lowEn);
    end
  endtask

  task automatic test_dead_cmd_change();
    int deadCycles = 0;
    Forward1 = 1'b1; Backwards1 = 1'b0;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (deadL !== 1'b1) break;
      deadCycles++;
      tests++;
      if (dutOuts !== expOuts) begin
        fails++;
        $display("FAIL deadcmd_model t=%0t got=%b want=%b", $time, dutOuts, expOuts);
      end
      if (deadCycles == 5) Forward1 = 1'b0;
      if (deadCycles == 15) Forward1 = 1'b1;
    end
    tests++;
    if (deadCycles != DC || {IN1, IN2} !== 2'b10) begin
      fails++;
      $display("FAIL deadcmd_len got=%0d IN1IN2=%b want=%0d 10", deadCycles, {IN1, IN2}, DC);
    end
    deadCycles = 0;
    Forward1 = 1'b0; Backwards1 = 1'b1;
    for (int g = 0; g < 100; g++) begin
      tick();
      Backwards1 = 1'b0;
      if (deadL !== 1'b1) break;
      deadCycles++;
    end
    tests++;
    if (deadCycles != DC || {IN1, IN2, ENA} !== 3'b000) begin
      fails++;
      $display("FAIL deadstop_idle got=%0d pins=%b want=%0d 000", deadCycles, {IN1, IN2, ENA}, DC);
    end
    repeat (5) tick();
    tests++;
    if (dutOuts !== expOuts || {IN1, IN2} !== 2'b00) begin
      fails++;
      $display("FAIL deadstop_stays got=%b want=%b", dutOuts, expOuts);
    end
  endtask

  task automatic test_reset_mid_dead();
    Forward1 = 1'b1; Backwards1 = 1'b0;
    tick();
    Forward1 = 1'b0; Backwards1 = 1'b1;
    tick();
    repeat (9) tick();
    tests++;
    if (deadL !== 1'b1) begin
      fails++;
      $display("FAIL middead_precond got deadL=%b want=1", deadL);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (dutOuts !== 8'h00) begin
      fails++;
      $display("FAIL middead_reset got=%b want=00000000", dutOuts);
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({IN1, IN2, deadL} !== 3'b010) begin
      fails++;
      $display("FAIL middead_release got IN1IN2dead=%b want=010", {IN1, IN2, deadL});
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 60; seg++) begin
      Forward1   = ($urandom_range(0, 2) != 0);
      Backwards1 = ($urandom_range(0, 2) == 0);
      Forward2   = ($urandom_range(0, 1) != 0);
      Backwards2 = ($urandom_range(0, 1) != 0);
      speedL     = 2'($urandom_range(0, 3));
      speedR     = 2'($urandom_range(0, 3));
      reset      = ($urandom_range(0, 19) == 0);
      hold       = reset ? 1 : $urandom_range(1, 60);
      for (int i = 0; i < hold; i++) begin
        tick();
        reset = 1'b0;
        tests++;
        if (dutOuts !== expOuts) begin
          fails++;
          $display("FAIL random_model seg=%0d t=%0t got=%b want=%b", seg, $time, dutOuts, expOuts);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_speed_change();
    test_reversal();
    test_illegal();
    test_dead_cmd_change();
    test_reset_mid_dead();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
